// File: rtl/tdc_result_reader.sv
// tdc_result_reader: SPI mode-0 master reading TIME1/CALIB1/CALIB2 from a TDC7200.
// Latency: done pulses 201*CLK_DIV+1 cycles after the edge that samples start.
// Backpressure: none; a start seen while busy is dropped, never queued.
//
// Ports: clk/rst (async active-high); start (read request, IDLE only);
//        sclk/csb/mosi/miso (SPI to the TDC); busy/done (status);
//        time1/calib1/calib2 (24-bit results, updated together on done).
// Build option: define TDC_READER_INTB_EN to add intb_n; a synchronized
//        falling edge on it triggers a read exactly like start.
module tdc_result_reader #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        miso,
`ifdef TDC_READER_INTB_EN
    input  logic        intb_n,
`endif
    output logic        sclk,
    output logic        csb,
    output logic        mosi,
    output logic        busy,
    output logic        done,
    output logic [23:0] time1,
    output logic [23:0] calib1,
    output logic [23:0] calib2
);

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF      = CW'(CLK_DIV);
    localparam logic [CW-1:0] FULL_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;       // clk cycles within a phase / SCLK period
    logic [4:0]      bit_cnt;   // SCLK period index 0..31
    logic [1:0]      reg_idx;   // 0: TIME1, 1: CALIB1, 2: CALIB2
    logic [7:0]      cmd;
    logic [23:0]     sr;
    logic [23:0]     stage0, stage1, stage2;
    logic            trig;

    // Command byte: auto-increment off, read, 6-bit address.
    function automatic logic [7:0] cmd_for(input logic [1:0] idx);
        case (idx)
            2'd0:    cmd_for = 8'h10;
            2'd1:    cmd_for = 8'h1B;
            default: cmd_for = 8'h1C;
        endcase
    endfunction

`ifdef TDC_READER_INTB_EN
    logic intb_s1, intb_s2, intb_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            intb_s1 <= 1'b1;
            intb_s2 <= 1'b1;
            intb_s3 <= 1'b1;
        end else begin
            intb_s1 <= intb_n;
            intb_s2 <= intb_s1;
            intb_s3 <= intb_s2;
        end
    end

    // Falling edge of the synchronized interrupt acts as an extra start.
    assign trig = start | (intb_s3 & ~intb_s2);
`else
    assign trig = start;
`endif

    // Outputs are written from the current state, so every pin lags the
    // state register by one cycle; phase lengths are counted on the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            reg_idx <= '0;
            cmd     <= '0;
            sr      <= '0;
            stage0  <= '0;
            stage1  <= '0;
            stage2  <= '0;
            csb     <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            time1   <= '0;
            calib1  <= '0;
            calib2  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    csb     <= 1'b1;
                    sclk    <= 1'b0;
                    mosi    <= 1'b0;
                    busy    <= 1'b0;
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (trig) begin
                        reg_idx <= 2'd0;
                        cmd     <= cmd_for(2'd0);
                        state   <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    csb  <= 1'b0;
                    busy <= 1'b1;
                    mosi <= cmd[7];
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                SHIFT: begin
                    // First half of each period: SCLK high, MISO captured on the rise.
                    if (cnt == '0) begin
                        sclk <= 1'b1;
                        if (bit_cnt >= 5'd8) begin
                            sr <= {sr[22:0], miso};
                        end
                    end
                    // Falling edge: present the next command bit, zeros afterwards.
                    if (cnt == HALF) begin
                        sclk <= 1'b0;
                        mosi <= (bit_cnt < 5'd7) ? cmd[3'd6 - bit_cnt[2:0]] : 1'b0;
                    end
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (bit_cnt == 5'd31) begin
                            state <= CS_HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                CS_HOLD: begin
                    sclk <= 1'b0;
                    mosi <= 1'b0;
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        case (reg_idx)
                            2'd0:    stage0 <= sr;
                            2'd1:    stage1 <= sr;
                            default: stage2 <= sr;
                        endcase
                        state <= GAP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                GAP: begin
                    csb <= 1'b1;
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (reg_idx == 2'd2) begin
                            state <= DONE;
                        end else begin
                            reg_idx <= reg_idx + 2'd1;
                            cmd     <= cmd_for(reg_idx + 2'd1);
                            state   <= CS_SETUP;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    // Publish all three together so consumers never see a mix.
                    done   <= 1'b1;
                    time1  <= stage0;
                    calib1 <= stage1;
                    calib2 <= stage2;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_result_reader.sv
// tb_tdc_result_reader: randomized stimulus against a cycle-level model of the
// SPI read sequence, plus a mode-0 slave that answers per register address.
// Terminates on its own; a watchdog stops a hung run.
module tb_tdc_result_reader;
    localparam int D   = 4;
    localparam int SEQ = 201 * D;   // cycles of bus activity per three-register read

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        miso = 1'b0;
    logic        intb_n = 1'b1;
    logic        sclk, csb, mosi, busy, done;
    logic [23:0] time1, calib1, calib2;

    tdc_result_reader #(.CLK_DIV(D)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .miso   (miso),
`ifdef TDC_READER_INTB_EN
        .intb_n (intb_n),
`endif
        .sclk   (sclk),
        .csb    (csb),
        .mosi   (mosi),
        .busy   (busy),
        .done   (done),
        .time1  (time1),
        .calib1 (calib1),
        .calib2 (calib2)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] cmd_of(input int r);
        case (r)
            0:       cmd_of = 8'h10;
            1:       cmd_of = 8'h1B;
            default: cmd_of = 8'h1C;
        endcase
    endfunction

    // ---------------- slave data and model ----------------
    logic [23:0] d_t1 = '0, d_c1 = '0, d_c2 = '0;   // what the slave returns now
    logic [23:0] sn_t1, sn_c1, sn_c2;               // snapshot taken at acceptance
    logic [23:0] e_t1 = '0, e_c1 = '0, e_c2 = '0;   // expected published results
    bit          m_active = 1'b0;
    int          m_S = 0;                           // edge that accepted the read
    bit          trig;
    bit          p1 = 1'b1, p2 = 1'b1, p3 = 1'b1;   // intb_n seen at the last 3 edges

    function automatic logic [23:0] slave_data(input logic [7:0] c);
        case (c)
            8'h10:   slave_data = d_t1;
            8'h1B:   slave_data = d_c1;
            8'h1C:   slave_data = d_c2;
            default: slave_data = 24'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_active = 1'b0;
            e_t1 = '0; e_c1 = '0; e_c2 = '0;
            p1 = 1'b1; p2 = 1'b1; p3 = 1'b1;
        end else begin
            trig = start;
`ifdef TDC_READER_INTB_EN
            // A pin fall is acted on at the third edge after it.
            trig = trig | (!p2 && p3);
            p3 = p2; p2 = p1; p1 = intb_n;
`endif
            if (m_active && cyc == m_S + SEQ + 1) begin
                e_t1 = sn_t1; e_c1 = sn_c1; e_c2 = sn_c2;
            end
            // Idle again once the DONE cycle and the following IDLE cycle have passed.
            if (trig && (!m_active || cyc >= m_S + SEQ + 2)) begin
                m_active = 1'b1;
                m_S = cyc;
                sn_t1 = d_t1; sn_c1 = d_c1; sn_c2 = d_c2;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int done_cnt = 0;
    always @(negedge clk) begin
        bit ec, es, em, ed, eb;
        int o, w, r, k;
        logic [7:0] cb;
        ec = 1'b1; es = 1'b0; em = 1'b0; ed = 1'b0; eb = 1'b0;
        if (m_active && !rst) begin
            o = cyc - m_S - 1;
            if (o >= 0 && o < SEQ) begin
                r = o / (67 * D);
                w = o % (67 * D);
                if (w < 66 * D) begin
                    ec = 1'b0;
                    if (w >= D && w < 65 * D && ((w - D) % (2 * D)) < D) es = 1'b1;
                    k = w / (2 * D);
                    cb = cmd_of(r);
                    if (k < 8) em = cb[7 - k];
                end
            end
            ed = (cyc == m_S + SEQ + 1);
            eb = (cyc >= m_S + 1 && cyc <= m_S + SEQ + 1);
        end
        chk("csb", csb, ec);
        chk("sclk", sclk, es);
        chk("mosi", mosi, em);
        chk("done", done, ed);
        chk("busy", busy, eb);
        chk("time1", time1, rst ? 24'h0 : e_t1);
        chk("calib1", calib1, rst ? 24'h0 : e_c1);
        chk("calib2", calib2, rst ? 24'h0 : e_c2);
        if (done) done_cnt++;
    end

    // ---------------- SPI slave / bus observer ----------------
    int          rises = 0;
    logic [7:0]  cmd_cap = '0;
    logic [23:0] dv;
    bit          in_win = 1'b0;
    int          mosi_err = 0;
    int          q_rises[$];
    logic [7:0]  q_cmd[$];

    always @(posedge sclk or negedge sclk or posedge csb) begin
        if (csb === 1'b1) begin
            if (in_win) begin
                q_rises.push_back(rises);
                q_cmd.push_back(cmd_cap);
            end
            in_win = 1'b0; rises = 0; cmd_cap = '0; miso = 1'b0;
        end else if (sclk === 1'b1) begin
            in_win = 1'b1;
            if (rises < 8) cmd_cap = {cmd_cap[6:0], mosi};
            else if (mosi !== 1'b0) mosi_err++;
            rises++;
        end else if (rises >= 8 && rises < 32) begin
            dv = slave_data(cmd_cap);
            miso = dv[31 - rises];
        end else begin
            miso = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(output int s);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 s = cyc; start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int e);
        bit f;
        f = 1'b0;
        e = -1;
        for (int i = 0; i < budget && !f; i++) begin
            @(negedge clk);
            if (done) begin f = 1'b1; e = cyc; end
        end
        chk("done_seen", f, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish at edge %0d", cyc);
        $fatal(1);
    end

    initial begin
        int s, e, prev_e, base, err0, dc0;
        logic [23:0] t[3], c1[3], c2[3];
        logic [7:0] exp_cmd[3];
        exp_cmd = '{8'h10, 8'h1B, 8'h1C};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_csb", csb, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_time1", time1, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Default read with fixed slave data.
        d_t1 = 24'h123456; d_c1 = 24'hABCDEF; d_c2 = 24'h000FFF;
        base = q_rises.size(); err0 = mosi_err;
        pulse_start(s);
        wait_done(1000, e);
        chk("done_latency", e - s, 805);
        chk("A_time1", time1, 24'h123456);
        chk("A_calib1", calib1, 24'hABCDEF);
        chk("A_calib2", calib2, 24'h000FFF);
        @(negedge clk);
        chk("A_windows", q_rises.size() - base, 3);
        for (int i = 0; i < 3; i++) begin
            if (base + i < q_rises.size()) begin
                chk("A_rises", q_rises[base + i], 32);
                chk("A_cmd", q_cmd[base + i], exp_cmd[i]);
            end
        end
        chk("A_mosi_data_zero", mosi_err - err0, 0);

        // Start pulses during a read are ignored.
        repeat (5) @(posedge clk);
        d_t1 = 24'($urandom); d_c1 = 24'($urandom); d_c2 = 24'($urandom);
        t[0] = d_t1; c1[0] = d_c1; c2[0] = d_c2;
        dc0 = done_cnt;
        pulse_start(s);
        repeat (99) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (399) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(1000, e);
        chk("B_latency", e - s, 805);
        chk("B_time1", time1, t[0]);
        chk("B_calib1", calib1, c1[0]);
        chk("B_calib2", calib2, c2[0]);
        repeat (900) @(posedge clk);
        chk("B_done_count", done_cnt - dc0, 1);

        // Reset in the middle of a transfer.
        d_t1 = 24'($urandom); d_c1 = 24'($urandom); d_c2 = 24'($urandom);
        pulse_start(s);
        repeat (299) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("R_csb", csb, 1);
        chk("R_sclk", sclk, 0);
        chk("R_busy", busy, 0);
        chk("R_time1", time1, 0);
        chk("R_calib1", calib1, 0);
        chk("R_calib2", calib2, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        d_t1 = 24'h000001; d_c1 = 24'h000002; d_c2 = 24'h000003;
        pulse_start(s);
        wait_done(1000, e);
        chk("R2_time1", time1, 24'h000001);
        chk("R2_calib1", calib1, 24'h000002);
        chk("R2_calib2", calib2, 24'h000003);

        // Held start: back-to-back reads, new slave data each time.
        repeat (5) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            t[i] = 24'($urandom); c1[i] = 24'($urandom); c2[i] = 24'($urandom);
        end
        d_t1 = t[0]; d_c1 = c1[0]; d_c2 = c2[0];
        #1 start = 1'b1;
        prev_e = -1;
        for (int i = 0; i < 3; i++) begin
            wait_done(1000, e);
            // Change slave data before the next read is accepted.
            if (i < 2) begin
                d_t1 = t[i + 1]; d_c1 = c1[i + 1]; d_c2 = c2[i + 1];
            end else begin
                start = 1'b0;
            end
            chk("C_time1", time1, t[i]);
            chk("C_calib1", calib1, c1[i]);
            chk("C_calib2", calib2, c2[i]);
            // Each re-trigger waits for the DONE cycle plus one IDLE cycle.
            if (prev_e >= 0) chk("C_period", e - prev_e, SEQ + 2);
            prev_e = e;
        end
        repeat (900) @(posedge clk);
        #1 chk("C_idle_busy", busy, 0);

`ifdef TDC_READER_INTB_EN
        begin
            int n0, ecs;
            bit f;
            d_t1 = 24'($urandom); d_c1 = 24'($urandom); d_c2 = 24'($urandom);
            t[0] = d_t1; c1[0] = d_c1; c2[0] = d_c2;
            dc0 = done_cnt;
            @(posedge clk); #1 intb_n = 1'b0;
            n0 = cyc; ecs = -1; f = 1'b0;
            for (int i = 0; i < 20 && !f; i++) begin
                @(posedge clk); #1;
                if (csb === 1'b0) begin f = 1'b1; ecs = cyc; end
            end
            chk("I_csb_fell", f, 1);
            chk("I_latency", ecs - n0, 4);
            repeat (50) @(posedge clk);
            #1 intb_n = 1'b1;
            repeat (50) @(posedge clk);
            #1 intb_n = 1'b0;
            wait_done(1000, e);
            chk("I_time1", time1, t[0]);
            chk("I_calib1", calib1, c1[0]);
            chk("I_calib2", calib2, c2[0]);
            repeat (900) @(posedge clk);
            chk("I_done_count", done_cnt - dc0, 1);
            #1 intb_n = 1'b1;
            repeat (10) @(posedge clk);
        end
`endif

        repeat (10) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
